// File: rtl/peripheral_gcd_pkg.sv
// Shared definitions for the GCD peripheral: register offsets, STATUS bit
// positions and the core FSM state encoding.
package peripheral_gcd_pkg;

  localparam logic [4:0] GCD_OFS_A      = 5'h00;
  localparam logic [4:0] GCD_OFS_B      = 5'h04;
  localparam logic [4:0] GCD_OFS_INIT   = 5'h08;
  localparam logic [4:0] GCD_OFS_STATUS = 5'h0C;
  localparam logic [4:0] GCD_OFS_RESULT = 5'h10;

  localparam int GCD_STATUS_DONE_BIT = 0;
  localparam int GCD_STATUS_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/peripheral_gcd_core.sv
// Binary (Stein) GCD engine: one reduction step per cycle, result and busy
// registered, done_pulse high for the single cycle after FIN.
module gcd_core
  import peripheral_gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done_pulse,
  output logic [WIDTH-1:0] gcd_out
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gcd_state_e       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] gcd_reg;
  logic             busy_reg;
  logic             done_pulse_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      k_reg          <= '0;
      res_reg        <= '0;
      gcd_reg        <= '0;
      busy_reg       <= 1'b0;
      done_pulse_reg <= 1'b0;
    end else begin
      done_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Termination tests come first so the subtract branches never underflow.
          if (a_reg == '0) begin
            res_reg   <= b_reg << k_reg;
            state_reg <= FIN;
          end else if (b_reg == '0) begin
            res_reg   <= a_reg << k_reg;
            state_reg <= FIN;
          end else if (a_reg == b_reg) begin
            res_reg   <= a_reg << k_reg;
            state_reg <= FIN;
          end else if (!a_reg[0] && !b_reg[0]) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            k_reg <= k_reg + KW'(1);
          end else if (!a_reg[0]) begin
            a_reg <= a_reg >> 1;
          end else if (!b_reg[0]) begin
            b_reg <= b_reg >> 1;
          end else if (a_reg > b_reg) begin
            a_reg <= (a_reg - b_reg) >> 1;
          end else begin
            b_reg <= (b_reg - a_reg) >> 1;
          end
        end
        FIN: begin
          gcd_reg        <= res_reg;
          busy_reg       <= 1'b0;
          done_pulse_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done_pulse = done_pulse_reg;
  assign gcd_out    = gcd_reg;

endmodule

// File: rtl/peripheral_gcd.sv
// Memory-mapped GCD responder: operand registers, bus decode, registered
// read port and the sticky done flag around gcd_core.
module peripheral_gcd
  import peripheral_gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_in,
  input  logic             cs,
  input  logic [4:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [31:0]      d_out
);

  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             done_hold_reg;
  logic [31:0]      d_out_reg;
  logic [31:0]      rd_data_next;

  logic             core_busy;
  logic             core_done_pulse;
  logic [WIDTH-1:0] core_result;

  logic wr_en;
  logic rd_en;
  logic start;
  logic done;

  assign wr_en = cs & wr;
  assign rd_en = cs & rd;
  assign start = wr_en && (addr == GCD_OFS_INIT) && d_in[0] && !core_busy;

  // The pulse covers the cycle before done_hold_reg catches it, so STATUS
  // shows done on the same edge the core publishes its result.
  assign done = done_hold_reg | core_done_pulse;

  gcd_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .a_in      (op_a_reg),
    .b_in      (op_b_reg),
    .busy      (core_busy),
    .done_pulse(core_done_pulse),
    .gcd_out   (core_result)
  );

  logic [31:0] op_a_ext;
  logic [31:0] op_b_ext;
  logic [31:0] result_ext;

  for (genvar gi = 0; gi < 32; gi++) begin : g_zext
    if (gi < WIDTH) begin : g_bit
      assign op_a_ext[gi]   = op_a_reg[gi];
      assign op_b_ext[gi]   = op_b_reg[gi];
      assign result_ext[gi] = core_result[gi];
    end else begin : g_pad
      assign op_a_ext[gi]   = 1'b0;
      assign op_b_ext[gi]   = 1'b0;
      assign result_ext[gi] = 1'b0;
    end
  end

  always_comb begin
    rd_data_next = '0;
    case (addr)
      GCD_OFS_A:      rd_data_next = op_a_ext;
      GCD_OFS_B:      rd_data_next = op_b_ext;
      GCD_OFS_STATUS: begin
        rd_data_next[GCD_STATUS_DONE_BIT] = done;
        rd_data_next[GCD_STATUS_BUSY_BIT] = core_busy;
      end
      GCD_OFS_RESULT: rd_data_next = result_ext;
      default:        rd_data_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      done_hold_reg <= 1'b0;
      d_out_reg     <= '0;
    end else begin
      if (wr_en && !core_busy) begin
        if (addr == GCD_OFS_A) op_a_reg <= d_in;
        if (addr == GCD_OFS_B) op_b_reg <= d_in;
      end
      if (start) begin
        done_hold_reg <= 1'b0;
      end else if (core_done_pulse) begin
        done_hold_reg <= 1'b1;
      end
      if (rd_en) d_out_reg <= rd_data_next;
    end
  end

  assign d_out = d_out_reg;

endmodule

// File: tb/tb_peripheral_gcd.sv
// Directed bench for peripheral_gcd: hand-computed GCD vectors, latency,
// busy protection, mid-run reset and bus-protocol corner cases.
module tb_peripheral_gcd;

  localparam int WIDTH = 16;
  localparam int POLL_LIMIT = 40;

  localparam logic [4:0] OFS_A      = 5'h00;
  localparam logic [4:0] OFS_B      = 5'h04;
  localparam logic [4:0] OFS_INIT   = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_RESULT = 5'h10;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] d_in;
  logic             cs;
  logic [4:0]       addr;
  logic             rd;
  logic             wr;
  logic [31:0]      d_out;

  int vec_cnt;
  int err_cnt;

  peripheral_gcd #(
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("  ok %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [WIDTH-1:0] data);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] data);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
    data = d_out;
  endtask

  task automatic start_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus_write(OFS_A, a);
    bus_write(OFS_B, b);
    bus_write(OFS_INIT, 16'h0001);
  endtask

  // Back-to-back STATUS reads; the read on edge i reports state before edge i,
  // so done rising on edge n is first seen by read i = n+1. lat=-1 on timeout.
  task automatic wait_done(output int lat, output logic [31:0] status);
    logic [31:0] s;
    lat = -1;
    status = '0;
    for (int i = 1; i <= POLL_LIMIT; i++) begin
      bus_read(OFS_STATUS, s);
      if (s[0]) begin
        lat = i - 1;
        status = s;
        break;
      end
    end
  endtask

  task automatic run_vector(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [31:0] exp, input int exact_lat);
    int lat;
    logic [31:0] st;
    logic [31:0] res;
    start_gcd(a, b);
    wait_done(lat, st);
    if (lat < 0) begin
      check_eq({tag, " done timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, " status"}, st, 32'h1);
      if (exact_lat > 0) check_eq({tag, " latency"}, 32'(lat), 32'(exact_lat));
      else check_eq({tag, " latency<=34"}, 32'(lat <= 34), 32'd1);
    end
    bus_read(OFS_RESULT, res);
    check_eq({tag, " result"}, res, exp);
  endtask

  logic [31:0] rdata;
  int          lat;
  logic [31:0] st;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    check_eq("reset d_out", d_out, 32'h0);
    bus_read(OFS_STATUS, rdata); check_eq("reset status", rdata, 32'h0);
    bus_read(OFS_RESULT, rdata); check_eq("reset result", rdata, 32'h0);
    bus_read(OFS_A, rdata);      check_eq("reset opA", rdata, 32'h0);

    run_vector("gcd(48,18)", 16'd48, 16'd18, 32'd6, 0);
    run_vector("gcd(0,0)", 16'd0, 16'd0, 32'd0, 2);
    run_vector("gcd(0,7)", 16'd0, 16'd7, 32'd7, 2);
    run_vector("gcd(7,0)", 16'd7, 16'd0, 32'd7, 2);
    run_vector("gcd(65535,65535)", 16'hFFFF, 16'hFFFF, 32'd65535, 0);
    run_vector("gcd(32768,49152)", 16'd32768, 16'd49152, 32'd16384, 0);
    run_vector("gcd(65521,65519)", 16'd65521, 16'd65519, 32'd1, 0);

    // Busy protection: operand and INIT writes during a run are dropped.
    start_gcd(16'd48, 16'd18);
    bus_write(OFS_A, 16'd100);
    bus_write(OFS_INIT, 16'h0001);
    wait_done(lat, st);
    check_eq("busy-prot done seen", 32'(lat >= 0), 32'd1);
    bus_read(OFS_RESULT, rdata); check_eq("busy-prot result", rdata, 32'd6);
    bus_read(OFS_A, rdata);      check_eq("busy-prot opA", rdata, 32'd48);
    bus_write(OFS_INIT, 16'h0001);
    wait_done(lat, st);
    check_eq("re-init done seen", 32'(lat >= 0), 32'd1);
    bus_read(OFS_RESULT, rdata); check_eq("re-init result", rdata, 32'd6);

    // INIT with bit0 clear must not restart: done stays set.
    bus_write(OFS_INIT, 16'h0002);
    bus_read(OFS_STATUS, rdata); check_eq("init bit0=0 ignored", rdata, 32'h1);

    // Reset during a long computation.
    start_gcd(16'd65521, 16'd65519);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_eq("midrst d_out", d_out, 32'h0);
    bus_read(OFS_STATUS, rdata); check_eq("midrst status", rdata, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    bus_read(OFS_STATUS, rdata); check_eq("midrst status later", rdata, 32'h0);
    bus_read(OFS_RESULT, rdata); check_eq("midrst result", rdata, 32'h0);
    run_vector("gcd(12,8)", 16'd12, 16'd8, 32'd4, 0);

    // Read with cs low leaves d_out alone (last read returned 4).
    rd = 1'b1; addr = OFS_STATUS;
    @(posedge clk);
    #1;
    rd = 1'b0;
    check_eq("cs=0 read holds", d_out, 32'd4);

    bus_read(5'h14, rdata); check_eq("unmapped read", rdata, 32'h0);

    // d_out must not move until the edge that samples cs&rd.
    cs = 1'b1; rd = 1'b1; addr = OFS_A;
    #1;
    check_eq("pre-edge d_out", d_out, 32'h0);
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
    check_eq("post-edge d_out", d_out, 32'd12);

    // Simultaneous write and read: read returns the pre-write value.
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = OFS_A; d_in = 16'd99;
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; d_in = '0;
    check_eq("rd+wr old value", d_out, 32'd12);
    bus_read(OFS_A, rdata); check_eq("rd+wr new value", rdata, 32'd99);

    // Unmapped write ignored.
    bus_write(5'h14, 16'hBEEF);
    bus_read(OFS_B, rdata); check_eq("unmapped write opB", rdata, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
